// File: rtl/joystick_serial_reader.sv
// Polls an NES-style serial game-pad, debounces the sampled button vector and
// presents it as a stable active-high bus with change and end-of-frame strobes.
module joystick_serial_reader #(
  parameter int CLK_DIV        = 4,
  parameter int POLL_PERIOD    = 100,
  parameter int DEBOUNCE_POLLS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       changed,
  output logic       frame_done
);

  localparam int TMR_W = $clog2(POLL_PERIOD);
  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_POLLS + 1);

  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_PERIOD - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEBOUNCE_POLLS);

  typedef enum logic [2:0] {IDLE, LATCH, FIRST, SHIFT_HI, SHIFT_LO, EVAL} state_t;

  state_t           state, state_next;
  logic [1:0]       sync;
  logic             pad_sync;
  logic [TMR_W-1:0] timer;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       raw;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             phase_last, sample, update;
  logic             latch_d, pclk_d;

  // Idle level of the pad line is high (released), so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync <= 2'b11;
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // which is what makes the two-stage synchronizer actually two stages.
    else          sync <= {sync[0], pad_data};
  end
  assign pad_sync = sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            timer <= '0;
    else if (!enable)        timer <= '0;
    else if (timer == TMR_LAST) timer <= '0;
    else                     timer <= timer + TMR_W'(1);
  end

  always_comb begin
    // NOTE: a default for every comb output avoids inferred latches on
    // paths the case statement does not cover.
    phase_last = 1'b0;
    case (state)
      LATCH:                     phase_last = (div_cnt == LATCH_LAST);
      FIRST, SHIFT_HI, SHIFT_LO: phase_last = (div_cnt == PHASE_LAST);
      default:                   phase_last = 1'b0;
    endcase
  end

  assign sample = phase_last && (state == FIRST || state == SHIFT_LO);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (timer == TMR_LAST) state_next = LATCH;
      LATCH:    if (phase_last) state_next = FIRST;
      FIRST:    if (phase_last) state_next = SHIFT_HI;
      SHIFT_HI: if (phase_last) state_next = SHIFT_LO;
      SHIFT_LO: if (phase_last) state_next = (bit_idx == 3'd7) ? EVAL : SHIFT_HI;
      EVAL:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Pad strobes are decoded from the next state so they can be registered
  // and still line up exactly with the state they belong to.
  always_comb begin
    latch_d = (state_next == LATCH);
    pclk_d  = (state_next == SHIFT_HI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_idx <= '0;
      raw     <= '0;
    end else begin
      div_cnt <= (state_next != state || state == IDLE) ? '0 : div_cnt + DIV_W'(1);
      if (state == IDLE) bit_idx <= '0;
      else if (sample) begin
        raw[bit_idx] <= ~pad_sync;
        bit_idx      <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    if (raw == cand) cnt_next = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
    else             cnt_next = CNT_W'(1);
    update = (cnt_next == CNT_FULL) && (raw != buttons);
  end

  // NOTE: only control/output flops need the async reset here; every flop in
  // this block is small state, so all of them are reset for a clean restart.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pad_latch  <= 1'b0;
      pad_clk    <= 1'b0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
      buttons    <= '0;
      cand       <= '0;
      cnt        <= '0;
    end else begin
      pad_latch  <= latch_d;
      pad_clk    <= pclk_d;
      frame_done <= (state == EVAL);
      changed    <= (state == EVAL) && update;
      if (state == EVAL) begin
        cand <= raw;
        cnt  <= cnt_next;
        if (update) buttons <= raw;
      end
    end
  end

endmodule

// File: doc/joystick_serial_reader.md
# joystick_serial_reader

Producer side of the joystick PIO input path. It polls a serial latch/clock/data game-pad (NES-style 8-button shift register), debounces the sampled button vector, and drives a stable 8-bit active-high `buttons` bus. That bus connects directly to the `in_port` of the interrupt-capable joystick PIO on the Avalon fabric. A one-cycle `changed` strobe marks every debounced update.

## Interface
Parameters:
- CLK_DIV, 4: pad clock half-period in `clk` cycles; must be ≥ 4.
- POLL_PERIOD, 100: `clk` cycles between frame starts; must be ≥ 17*CLK_DIV + 2.
- DEBOUNCE_POLLS, 2: consecutive identical frames required before `buttons` updates; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block uses only this clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enable.
- pad_data  in  1  serial data from the pad; active-low (0 = pressed); asynchronous to `clk`.
- pad_latch  out  1  parallel-load strobe to the pad.
- pad_clk  out  1  shift clock to the pad.
- buttons  out  8  debounced button vector, active-high; bit0 is the first bit shifted out.
- changed  out  1  one-cycle pulse when `buttons` takes a new value.
- frame_done  out  1  one-cycle pulse at the end of every frame.

## Operation
- `pad_data` passes through a 2-flop synchronizer, reset value 1. All sampling uses the synchronized value.
- Poll timer:
  - While `enable`=1, counts 0..POLL_PERIOD-1 and wraps.
  - While `enable`=0, held at 0.
  - A frame starts when the timer is at POLL_PERIOD-1 and the FSM is IDLE.
- FSM states:
  - IDLE: outputs low.
  - LATCH: `pad_latch`=1 for 2*CLK_DIV cycles.
  - FIRST: `pad_clk`=0 for CLK_DIV cycles. Samples bit0 on the last cycle.
  - SHIFT_HI: `pad_clk`=1 for CLK_DIV cycles.
  - SHIFT_LO: `pad_clk`=0 for CLK_DIV cycles. Samples bit n on the last cycle.
  - EVAL: one cycle, then back to IDLE.
- Transitions:
  - SHIFT_HI/SHIFT_LO repeat for bits 1..7.
  - After bit7 is sampled, go to EVAL.
- Sample rule: raw[n] = ~pad_data_sync.
- Debounce, performed at the EVAL edge:
  - If raw == cand: cnt saturates upward at DEBOUNCE_POLLS.
  - Otherwise: cand <= raw, cnt <= 1.
  - If the new cnt == DEBOUNCE_POLLS and cand ≠ `buttons`: `buttons` <= cand and `changed` pulses.
  - With DEBOUNCE_POLLS=1, `buttons` follows every frame.
- `enable` falling mid-frame: the frame completes normally, including EVAL. No further frames start.
- Reset:
  - `pad_latch`, `pad_clk`, `buttons`, `changed`, `frame_done` all go to 0 immediately.
  - cand=0, cnt=0, timer=0, state IDLE.
  - A frame in progress is abandoned and its partial data discarded.

## Timing
- Frame length from LATCH entry to the last sample: 17*CLK_DIV cycles. EVAL adds one cycle.
- `pad_latch` rises in the cycle after the timer reads POLL_PERIOD-1.
- After the EVAL clock edge, `frame_done` and `changed` are high for exactly one cycle, and the new `buttons` value is visible in that same cycle.
- `buttons` changes only on that edge. It is held stable at all other times, which keeps the downstream level IRQ glitch-free.
- Pad-to-sample latency is 2 cycles (synchronizer). CLK_DIV ≥ 4 guarantees the pad settles before sampling.
- `pad_latch` and `pad_clk` are never high in the same cycle. Both are driven from registers (glitch-free).

## Test plan
Bench settings: CLK_DIV=4, POLL_PERIOD=100, DEBOUNCE_POLLS=2, with a pad model.

1. Reset held with `enable`=1 → all outputs 0 and no pad activity. After release, `pad_latch` rises at cycle 100 and is high 8 cycles, followed by exactly 7 `pad_clk` pulses (4 high / 4 low).
2. Pad pressed mask 8'hA5, constant → frame 1 leaves `buttons`=8'h00. Frame 2 ends with `buttons`=8'hA5 and a single `changed` pulse. Frame 3 gives `frame_done` but no `changed`.
3. Frames returning 8'h00, 8'h01, 8'h00, 8'h00 → `buttons` stays 8'h00 and `changed` never pulses.
4. `enable` dropped during SHIFT_HI of bit3 → that frame completes, `frame_done` pulses once, then no `pad_latch` for ≥ 300 cycles. Re-enable → next latch occurs 100 cycles later.
5. `reset_n` pulsed low during bit5 with `buttons`=8'hA5 → `pad_clk`=0 and `buttons`=8'h00 within the reset cycle. After release, the first latch occurs 100 cycles later and `buttons` returns to 8'hA5 after 2 frames.
6. DEBOUNCE_POLLS=1 with pad alternating 8'h0F/8'hF0 per frame → `buttons` alternates and `changed` pulses every frame.
